zeroheti_apb_arbiter: RTL and testbench

Shares the single zeroHETI peripheral APB bus between `NumMgr` APB managers (core load/store port, debug module, future DMA) using round-robin arbitration. Each manager-side transfer is re-issued downstream as a full APB SETUP/ACCESS sequence. A bus watchdog terminates any ACCESS phase that the selected peripheral never readies, returning an error to the manager. The block sits between the managers and the peripheral address decoder/demux.

---
 rtl/zeroheti_pkg.sv | 14 +
 rtl/zeroheti_rr_pick.sv | 30 +++
 rtl/zeroheti_apb_arbiter.sv | 139 +++++++++++++
 tb/tb_zeroheti_apb_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/zeroheti_pkg.sv
// Shared zeroHETI types and constants for the peripheral bus infrastructure.
package zeroheti_pkg;

    // Default ACCESS-phase budget before the APB arbiter aborts a transfer.
    localparam int unsigned ApbTimeoutCycles = 256;

    // Downstream APB phase tracked by the arbiter.
    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS
    } apb_arb_state_e;

endpackage

// File: rtl/zeroheti_rr_pick.sv
// Combinational round-robin picker: the first asserted request found
// scanning upward from last_i+1, wrapping around through last_i itself.
module zeroheti_rr_pick #(
    parameter int unsigned NumReq = 2,
    localparam int unsigned IdxW  = $clog2(NumReq)
) (
    input  logic [NumReq-1:0] req_i,
    input  logic [IdxW-1:0]   last_i,
    output logic              valid_o,
    output logic [IdxW-1:0]   idx_o
);

    // Scan from the farthest offset down to the nearest one so the nearest
    // requester after last_i is the one left standing.
    always_comb begin
        // NOTE: every output gets a default before the loop, otherwise the
        // "no request" path would infer a latch.
        valid_o = 1'b0;
        idx_o   = '0;
        for (int k = int'(NumReq); k >= 1; k--) begin
            int cand;
            cand = (int'(last_i) + k) % int'(NumReq);
            if (req_i[IdxW'(cand)]) begin
                valid_o = 1'b1;
                idx_o   = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/zeroheti_apb_arbiter.sv
// Round-robin arbiter sharing the zeroHETI peripheral APB bus between several
// APB managers. Each granted transfer is replayed downstream as SETUP/ACCESS;
// a watchdog aborts an ACCESS phase the peripheral never readies.
module zeroheti_apb_arbiter
    import zeroheti_pkg::*;
#(
    parameter int unsigned          NumMgr        = 2,
    parameter int unsigned          AddrWidth     = 32,
    parameter int unsigned          DataWidth     = 32,
    parameter int unsigned          TimeoutCycles = ApbTimeoutCycles,
    parameter logic [DataWidth-1:0] TimeoutData   = DataWidth'(32'hBADC_0DE5),
    localparam int unsigned         IdxW          = $clog2(NumMgr)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NumMgr-1:0]                m_psel_i,
    input  logic [NumMgr-1:0]                m_penable_i,
    input  logic [NumMgr-1:0]                m_pwrite_i,
    input  logic [NumMgr-1:0][AddrWidth-1:0] m_paddr_i,
    input  logic [NumMgr-1:0][DataWidth-1:0] m_pwdata_i,
    output logic [NumMgr-1:0][DataWidth-1:0] m_prdata_o,
    output logic [NumMgr-1:0]                m_pready_o,
    output logic [NumMgr-1:0]                m_pslverr_o,
    output logic                             s_psel_o,
    output logic                             s_penable_o,
    output logic                             s_pwrite_o,
    output logic [AddrWidth-1:0]             s_paddr_o,
    output logic [DataWidth-1:0]             s_pwdata_o,
    input  logic [DataWidth-1:0]             s_prdata_i,
    input  logic                             s_pready_i,
    input  logic                             s_pslverr_i,
    output logic [IdxW-1:0]                  grant_o,
    output logic                             busy_o,
    output logic                             timeout_o
);

    localparam bit          WdogEn  = (TimeoutCycles != 0);
    localparam int unsigned CntW    = WdogEn ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WdogEn ? TimeoutCycles - 1 : 0);

    apb_arb_state_e  state_q, state_d;
    logic [IdxW-1:0] grant_q, grant_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    logic            pick_valid;
    logic [IdxW-1:0] pick_idx;
    logic            expire;

    zeroheti_rr_pick #(
        .NumReq (NumMgr)
    ) i_rr_pick (
        .req_i   (m_psel_i),
        .last_i  (last_q),
        .valid_o (pick_valid),
        .idx_o   (pick_idx)
    );

    assign expire  = WdogEn && (cnt_q == CntLast) && !s_pready_i;
    assign grant_o = grant_q;
    assign busy_o  = (state_q != IDLE);

    // State, grant, round-robin pointer and watchdog registers.
    // This codebase's rst_ni is active-high despite its name.
    always_ff @(posedge clk_i or posedge rst_ni) begin
        if (rst_ni) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= IdxW'(NumMgr - 1);
            cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking updates so every register samples the
            // pre-edge value of the others, independent of statement order.
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic, downstream request mux and upstream response routing.
    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        s_psel_o    = 1'b0;
        s_penable_o = 1'b0;
        s_pwrite_o  = 1'b0;
        s_paddr_o   = '0;
        s_pwdata_o  = '0;
        m_pready_o  = '0;
        m_pslverr_o = '0;
        m_prdata_o  = '0;
        timeout_o   = 1'b0;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    grant_d = pick_idx;
                    last_d  = pick_idx;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                s_psel_o   = 1'b1;
                s_pwrite_o = m_pwrite_i[grant_q];
                s_paddr_o  = m_paddr_i[grant_q];
                s_pwdata_o = m_pwdata_i[grant_q];
                cnt_d      = '0;
                state_d    = ACCESS;
            end
            ACCESS: begin
                s_psel_o                = 1'b1;
                s_penable_o             = 1'b1;
                s_pwrite_o              = m_pwrite_i[grant_q];
                s_paddr_o               = m_paddr_i[grant_q];
                s_pwdata_o              = m_pwdata_i[grant_q];
                m_pready_o[grant_q]     = s_pready_i & m_penable_i[grant_q];
                m_pslverr_o[grant_q]    = s_pslverr_i;
                m_prdata_o[grant_q]     = s_prdata_i;
                if (s_pready_i) begin
                    state_d = IDLE;
                end else if (expire) begin
                    // Peripheral never answered: complete with an error.
                    m_pready_o[grant_q]  = 1'b1;
                    m_pslverr_o[grant_q] = 1'b1;
                    m_prdata_o[grant_q]  = TimeoutData;
                    timeout_o            = 1'b1;
                    state_d              = IDLE;
                end else if (WdogEn) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_zeroheti_apb_arbiter.sv
// Self-checking bench for zeroheti_apb_arbiter (2 managers, 8-cycle watchdog).
// Stimulus pushes expected responses; a monitor pops them on every m_pready_o.
module tb_zeroheti_apb_arbiter;

    localparam logic [31:0] TO_DATA = 32'hBADC_0DE5;
    localparam logic [31:0] RD_KEY  = 32'h5A5A_0000;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
        logic [7:0]  waits;
    } exp_t;

    logic clk    = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk = ~clk;

    logic        psel_m[2];
    logic        penable_m[2];
    logic        pwrite_m[2];
    logic [31:0] paddr_m[2];
    logic [31:0] pwdata_m[2];

    logic [1:0]       m_psel_i, m_penable_i, m_pwrite_i;
    logic [1:0][31:0] m_paddr_i, m_pwdata_i, m_prdata_o;
    logic [1:0]       m_pready_o, m_pslverr_o;
    logic             s_psel_o, s_penable_o, s_pwrite_o;
    logic [31:0]      s_paddr_o, s_pwdata_o, s_prdata_i;
    logic             s_pready_i, s_pslverr_i;
    logic [0:0]       grant_o;
    logic             busy_o, timeout_o;

    assign m_psel_i    = {psel_m[1], psel_m[0]};
    assign m_penable_i = {penable_m[1], penable_m[0]};
    assign m_pwrite_i  = {pwrite_m[1], pwrite_m[0]};
    assign m_paddr_i   = {paddr_m[1], paddr_m[0]};
    assign m_pwdata_i  = {pwdata_m[1], pwdata_m[0]};

    zeroheti_apb_arbiter #(
        .NumMgr        (2),
        .AddrWidth     (32),
        .DataWidth     (32),
        .TimeoutCycles (8),
        .TimeoutData   (TO_DATA)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .m_psel_i    (m_psel_i),
        .m_penable_i (m_penable_i),
        .m_pwrite_i  (m_pwrite_i),
        .m_paddr_i   (m_paddr_i),
        .m_pwdata_i  (m_pwdata_i),
        .m_prdata_o  (m_prdata_o),
        .m_pready_o  (m_pready_o),
        .m_pslverr_o (m_pslverr_o),
        .s_psel_o    (s_psel_o),
        .s_penable_o (s_penable_o),
        .s_pwrite_o  (s_pwrite_o),
        .s_paddr_o   (s_paddr_o),
        .s_pwdata_o  (s_pwdata_o),
        .s_prdata_i  (s_prdata_i),
        .s_pready_i  (s_pready_i),
        .s_pslverr_i (s_pslverr_i),
        .grant_o     (grant_o),
        .busy_o      (busy_o),
        .timeout_o   (timeout_o)
    );

    // Peripheral model: ready after periph_wait ACCESS cycles (-1 = never),
    // reads return addr ^ RD_KEY, error on addresses with bit 31 set.
    int          periph_wait = 0;
    int          acc_cnt     = 0;
    logic [31:0] wr_addr, wr_data;

    assign s_pready_i  = s_psel_o & s_penable_o & (acc_cnt == periph_wait);
    assign s_pslverr_i = s_pready_i & s_paddr_o[31];
    assign s_prdata_i  = (s_psel_o & s_penable_o & ~s_pwrite_o) ? (s_paddr_o ^ RD_KEY) : '0;

    always @(posedge clk) begin
        acc_cnt <= (s_psel_o && s_penable_o) ? acc_cnt + 1 : 0;
        if (s_psel_o && s_penable_o && s_pready_i && s_pwrite_o) begin
            wr_addr <= s_paddr_o;
            wr_data <= s_pwdata_o;
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int to_cnt   = 0;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   order_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input int mgr, input logic [31:0] rdata, input logic err, input int waits);
        exp_t e;
        e.rdata = rdata;
        e.err   = err;
        e.waits = 8'(waits);
        if (mgr == 0) exp_q0.push_back(e);
        else          exp_q1.push_back(e);
    endtask

    // Monitor: every upstream pready must match the next expected response.
    always @(negedge clk) begin
        if (!rst_ni) begin
            if (timeout_o) to_cnt++;
            for (int i = 0; i < 2; i++) begin
                if (m_pready_o[i]) begin
                    exp_t e;
                    bit   have;
                    have = 1'b0;
                    e    = '0;
                    if (i == 0 && exp_q0.size() > 0) begin have = 1'b1; e = exp_q0.pop_front(); end
                    if (i == 1 && exp_q1.size() > 0) begin have = 1'b1; e = exp_q1.pop_front(); end
                    check($sformatf("resp_expected_m%0d", i), 32'(have), 32'd1);
                    if (order_q.size() > 0) check("grant_order", 32'(i), 32'(order_q.pop_front()));
                    else                    check("grant_order_extra", 32'(i), 32'hFFFF_FFFF);
                    check("grant_o", 32'(grant_o), 32'(i));
                    if (have) begin
                        check($sformatf("prdata_m%0d", i), m_prdata_o[i], e.rdata);
                        check($sformatf("pslverr_m%0d", i), 32'(m_pslverr_o[i]), 32'(e.err));
                        check($sformatf("access_cycles_m%0d", i), 32'(acc_cnt), 32'(e.waits));
                    end
                end
            end
        end
    end

    // Full manager-side APB transfer with a bounded wait for pready.
    task automatic apb_xfer(input int mgr, input logic wr, input logic [31:0] addr,
                            input logic [31:0] data, input logic [31:0] exp_rdata,
                            input logic exp_err, input int exp_waits);
        bit got;
        push_exp(mgr, exp_rdata, exp_err, exp_waits);
        @(posedge clk); #1;
        psel_m[mgr]    = 1'b1;
        penable_m[mgr] = 1'b0;
        pwrite_m[mgr]  = wr;
        paddr_m[mgr]   = addr;
        pwdata_m[mgr]  = data;
        @(posedge clk); #1;
        penable_m[mgr] = 1'b1;
        got = 1'b0;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            got = m_pready_o[mgr];
        end
        check($sformatf("xfer_done_m%0d", mgr), 32'(got), 32'd1);
        @(posedge clk); #1;
        psel_m[mgr]    = 1'b0;
        penable_m[mgr] = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_ni = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit expired");
        $fatal(1, "bench time limit");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            psel_m[i] = 1'b0; penable_m[i] = 1'b0; pwrite_m[i] = 1'b0;
            paddr_m[i] = '0;  pwdata_m[i] = '0;
        end

        // Reset state.
        @(negedge clk);
        check("rst_s_psel", 32'(s_psel_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        check("rst_grant", 32'(grant_o), 0);
        check("rst_m_pready", 32'(m_pready_o), 0);
        check("rst_timeout", 32'(timeout_o), 0);
        @(posedge clk); #1 rst_ni = 1'b0;

        // Single write from manager 0, zero-wait peripheral, cycle-by-cycle.
        order_q.push_back(0);
        push_exp(0, 32'h0, 1'b0, 0);
        @(posedge clk); #1;
        psel_m[0] = 1'b1; pwrite_m[0] = 1'b1;
        paddr_m[0] = 32'h0003_0000; pwdata_m[0] = 32'h1234_5678;
        @(negedge clk);
        check("c0_s_psel", 32'(s_psel_o), 0);
        @(posedge clk); #1 penable_m[0] = 1'b1;
        @(negedge clk);
        check("c1_s_psel", 32'(s_psel_o), 1);
        check("c1_s_penable", 32'(s_penable_o), 0);
        check("c1_s_paddr", s_paddr_o, 32'h0003_0000);
        check("c1_busy", 32'(busy_o), 1);
        @(negedge clk);
        check("c2_s_psel", 32'(s_psel_o), 1);
        check("c2_s_penable", 32'(s_penable_o), 1);
        check("c2_m_pready0", 32'(m_pready_o[0]), 1);
        check("c2_s_pwdata", s_pwdata_o, 32'h1234_5678);
        @(posedge clk); #1;
        psel_m[0] = 1'b0; penable_m[0] = 1'b0; pwrite_m[0] = 1'b0;
        @(negedge clk);
        check("c3_s_psel", 32'(s_psel_o), 0);
        check("c3_busy", 32'(busy_o), 0);
        check("wr_addr", wr_addr, 32'h0003_0000);
        check("wr_data", wr_data, 32'h1234_5678);

        // Simultaneous requests right after reset: 0 then 1.
        do_reset();
        order_q.push_back(0);
        order_q.push_back(1);
        fork
            apb_xfer(0, 1'b0, 32'h0001_0010, '0, 32'h5A5B_0010, 1'b0, 0);
            apb_xfer(1, 1'b0, 32'h0002_0020, '0, 32'h5A58_0020, 1'b0, 0);
        join

        // Continuous requests: grants alternate 0,1,0,1,0,1.
        for (int k = 0; k < 3; k++) begin
            order_q.push_back(0);
            order_q.push_back(1);
        end
        fork
            begin
                apb_xfer(0, 1'b0, 32'h0001_0100, '0, 32'h5A5B_0100, 1'b0, 0);
                apb_xfer(0, 1'b0, 32'h0001_0104, '0, 32'h5A5B_0104, 1'b0, 0);
                apb_xfer(0, 1'b0, 32'h0001_0108, '0, 32'h5A5B_0108, 1'b0, 0);
            end
            begin
                apb_xfer(1, 1'b0, 32'h0004_0200, '0, 32'h5A5E_0200, 1'b0, 0);
                apb_xfer(1, 1'b0, 32'h0004_0204, '0, 32'h5A5E_0204, 1'b0, 0);
                apb_xfer(1, 1'b0, 32'h0004_0208, '0, 32'h5A5E_0208, 1'b0, 0);
            end
        join

        // Peripheral never ready: watchdog abort on the 8th ACCESS cycle.
        to_cnt = 0;
        periph_wait = -1;
        order_q.push_back(0);
        apb_xfer(0, 1'b0, 32'h0003_0040, '0, TO_DATA, 1'b1, 7);
        @(negedge clk);
        check("to_pulses", 32'(to_cnt), 1);
        check("to_busy_after", 32'(busy_o), 0);

        // Ready exactly on the 8th ACCESS cycle: normal completion wins.
        to_cnt = 0;
        periph_wait = 7;
        order_q.push_back(1);
        apb_xfer(1, 1'b0, 32'h0003_0044, '0, 32'h5A59_0044, 1'b0, 7);
        check("late_ready_no_timeout", 32'(to_cnt), 0);

        // Peripheral error passes through.
        periph_wait = 0;
        order_q.push_back(0);
        apb_xfer(0, 1'b0, 32'h8000_0004, '0, 32'hDA5A_0004, 1'b1, 0);

        // Reset during ACCESS (last grant was 0, so without reset 1 would win next).
        periph_wait = -1;
        @(posedge clk); #1;
        psel_m[0] = 1'b1; pwrite_m[0] = 1'b0; paddr_m[0] = 32'h0005_0000;
        @(posedge clk); #1 penable_m[0] = 1'b1;
        repeat (3) @(negedge clk);
        check("pre_rst_in_access", 32'(s_penable_o), 1);
        #2 rst_ni = 1'b1;
        #1;
        check("rst_mid_s_psel", 32'(s_psel_o), 0);
        check("rst_mid_s_penable", 32'(s_penable_o), 0);
        check("rst_mid_s_paddr", s_paddr_o, 0);
        check("rst_mid_m_prdata", m_prdata_o[0], 0);
        check("rst_mid_busy", 32'(busy_o), 0);
        penable_m[0] = 1'b0;
        psel_m[1] = 1'b1; pwrite_m[1] = 1'b0; paddr_m[1] = 32'h0006_0000;
        @(posedge clk); #1 rst_ni = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("post_rst_setup", 32'(s_psel_o), 1);
        check("post_rst_grant", 32'(grant_o), 0);
        check("post_rst_paddr", s_paddr_o, 32'h0005_0000);
        rst_ni = 1'b1;
        psel_m[0] = 1'b0; psel_m[1] = 1'b0;
        @(posedge clk); #1 rst_ni = 1'b0;
        repeat (2) @(negedge clk);

        check("leftover_exp_m0", 32'(exp_q0.size()), 0);
        check("leftover_exp_m1", 32'(exp_q1.size()), 0);
        check("leftover_order", 32'(order_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
